// File: rtl/eu_scheduler.sv
// eu_scheduler: holds one configuration word per execution-unit slot, launches
// a masked batch of slots with one-cycle start pulses, waits for every launched
// slot to report done (or for the watchdog to expire), then reports completion.
//
// Handshake: a launch is accepted on a clock edge where exec_valid && exec_ready.
// exec_ready is combinational (state == IDLE); exec_mask is sampled only on that
// edge and may change freely otherwise. Every other output is registered.
module eu_scheduler #(
  parameter int NUM_EU    = 13,
  parameter int CFG_W     = 32,
  parameter int TIMEOUT_W = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_valid,
  input  logic [$clog2(NUM_EU)-1:0]   cfg_unit,
  input  logic [CFG_W-1:0]            cfg_data,
  input  logic                        exec_valid,
  input  logic [NUM_EU-1:0]           exec_mask,
  output logic                        exec_ready,
  output logic [NUM_EU-1:0]           eu_start,
  output logic [NUM_EU*CFG_W-1:0]     eu_cfg,
  input  logic [NUM_EU-1:0]           eu_done,
  output logic [NUM_EU-1:0]           eu_abort,
  output logic                        batch_done,
  output logic                        busy,
  output logic [NUM_EU-1:0]           pending,
  output logic [2:0]                  err,
  input  logic                        err_clr,
  output logic [31:0]                 perf_cycles
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t               state;
  logic [TIMEOUT_W-1:0] wd;
  logic [31:0]          acc;
  logic [CFG_W-1:0]     cfg_q [NUM_EU];

  logic [NUM_EU-1:0]    done_hit;
  logic [NUM_EU-1:0]    pend_after;
  logic [NUM_EU-1:0]    stray;
  logic [TIMEOUT_W-1:0] wd_next;
  logic                 expire;
  logic                 cfg_in_range;
  logic                 cfg_conflict;
  logic                 cfg_write;

  assign exec_ready = (state == S_IDLE);

  for (genvar g = 0; g < NUM_EU; g++) begin : g_cfg
    assign eu_cfg[g*CFG_W +: CFG_W] = cfg_q[g];
  end

  // Done matching, watchdog expiry and config-write legality for this cycle.
  // Dones only count while waiting; a done in LAUNCH is a protocol violation.
  always_comb begin
    done_hit     = (state == S_WAIT) ? (eu_done & pending) : '0;
    stray        = eu_done & ~done_hit;
    pend_after   = pending & ~done_hit;
    wd_next      = wd + 1'b1;
    expire       = (state == S_WAIT) && (&wd_next) && (|pend_after);
    cfg_in_range = (int'(cfg_unit) < NUM_EU);
    cfg_conflict = cfg_valid && cfg_in_range && pending[cfg_unit];
    cfg_write    = cfg_valid && cfg_in_range && !pending[cfg_unit];
  end

  // Batch FSM with all registered outputs, config store and sticky errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wd          <= '0;
      acc         <= '0;
      pending     <= '0;
      eu_start    <= '0;
      eu_abort    <= '0;
      batch_done  <= 1'b0;
      busy        <= 1'b0;
      err         <= '0;
      perf_cycles <= '0;
      for (int i = 0; i < NUM_EU; i++) cfg_q[i] <= '0;
    end else begin
      eu_start   <= '0;
      eu_abort   <= '0;
      batch_done <= 1'b0;
      // An error event in the same cycle as err_clr keeps its bit set.
      err <= (err & ~{3{err_clr}}) | {expire, cfg_conflict, |stray};
      // Checked against the pre-launch pending set, so a slot launched in
      // this same cycle still picks up the new word.
      if (cfg_write) cfg_q[cfg_unit] <= cfg_data;

      case (state)
        S_IDLE: begin
          if (exec_valid) begin
            busy <= 1'b1;
            if (|exec_mask) begin
              pending  <= exec_mask;
              eu_start <= exec_mask;
              state    <= S_LAUNCH;
            end else begin
              batch_done  <= 1'b1;
              perf_cycles <= '0;
              state       <= S_FINISH;
            end
          end
        end
        S_LAUNCH: begin
          wd    <= '0;
          acc   <= 32'd1;  // the LAUNCH cycle itself counts
          state <= S_WAIT;
        end
        S_WAIT: begin
          wd  <= wd_next;
          acc <= acc + 32'd1;
          if (pend_after == '0) begin
            pending     <= '0;
            batch_done  <= 1'b1;
            perf_cycles <= acc + 32'd1;
            state       <= S_FINISH;
          end else if (expire) begin
            eu_abort    <= pend_after;
            pending     <= '0;
            batch_done  <= 1'b1;
            perf_cycles <= acc + 32'd1;
            state       <= S_FINISH;
          end else begin
            pending <= pend_after;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/eu_scheduler.md
# eu_scheduler

Configures and sequences the execution units (stmm, layernorm, silu, att slots) on behalf of `ctrl_unit`. It holds a 32-bit configuration word per unit, launches a masked batch of units with single-cycle start pulses, and waits for every launched unit to report done. It enforces a cycle timeout, then reports batch completion and status back toward the MMIO path. It sits between `ctrl_unit` (eu_fetch/eu_exec side) and the execution units that attach to `rf_wrapper` through rmio.

## Interface
- `NUM_EU`, default 13: number of execution-unit slots; bit i of every mask refers to slot i.
- `CFG_W`, default 32: width of the per-unit configuration word.
- `TIMEOUT_W`, default 20: width of the batch watchdog counter; timeout after 2^TIMEOUT_W−1 WAIT cycles.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: synchronous, active-low reset.
- `cfg_valid` in 1: configuration write strobe.
- `cfg_unit` in $clog2(NUM_EU): target slot of the configuration write.
- `cfg_data` in CFG_W: configuration word.
- `exec_valid` in 1: batch launch request.
- `exec_mask` in NUM_EU: slots to launch.
- `exec_ready` out 1: launch accepted when `exec_valid && exec_ready`.
- `eu_start` out NUM_EU: one-cycle start pulse per slot.
- `eu_cfg` out NUM_EU*CFG_W: configuration register of every slot; slot i occupies bits [i*CFG_W +: CFG_W].
- `eu_done` in NUM_EU: one-cycle done pulse per slot.
- `eu_abort` out NUM_EU: one-cycle abort pulse to slots still pending at timeout.
- `batch_done` out 1: one-cycle pulse when a batch completes or aborts.
- `busy` out 1: high in every state except IDLE.
- `pending` out NUM_EU: slots launched and not yet done.
- `err` out 3: sticky errors: [0] stray done, [1] config write to a pending slot, [2] timeout.
- `err_clr` in 1: clears `err`.
- `perf_cycles` out 32: cycle count of the last completed batch, measured from the LAUNCH cycle through the completing cycle.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, FINISH.
- IDLE: `exec_ready`=1. An accepted `exec_mask` that is non-zero loads `pending` and moves to LAUNCH.
  - A zero mask is accepted and goes straight to FINISH.
  - Bits at or above NUM_EU are not representable, so out-of-range slots cannot be launched.
- LAUNCH, exactly 1 cycle: `eu_start` = `pending`. Clear the watchdog and `perf_cycles` accumulator, then go to WAIT.
- WAIT: each `eu_done[i]` with `pending[i]`=1 clears `pending[i]`.
  - Simultaneous done pulses from several slots all clear in the same cycle.
  - When `pending` becomes 0 (including this cycle's dones), go to FINISH.
  - `eu_done[i]` with `pending[i]`=0 is ignored and sets `err[0]`. This applies in every state.
- Watchdog: increments every WAIT cycle. When it reaches all-ones with `pending`≠0:
  - pulse `eu_abort` = `pending` and clear `pending`,
  - set `err[2]`,
  - go to FINISH.
  - A done arriving in the expiry cycle clears its bit first; the abort covers only the remainder.
- FINISH, 1 cycle: pulse `batch_done`, latch `perf_cycles`, return to IDLE.
- Config writes are accepted in any state.
  - If `pending[cfg_unit]`=1, the write is dropped and `err[1]` is set. Running units never see their config change.
  - If `cfg_unit` ≥ NUM_EU, the write is dropped and no error is raised.
- `err_clr` clears `err`. An error event in the same cycle wins, so the bit stays set.
- Reset (also mid-batch): state IDLE; `pending`, `eu_start`, `eu_abort`, `batch_done`, `err`, `perf_cycles` and all config registers are 0; `busy`=0; `exec_ready`=1. In-flight units are not aborted by reset; the units see `rst_n` themselves.

## Timing
- All outputs are registered except `exec_ready`, which is `state==IDLE`.
- Accept edge at cycle T:
  - LAUNCH in T+1, with `eu_start` visible in T+1.
  - Earliest WAIT is T+2.
  - Done pulses sampled in T+2 give FINISH in T+3 and `batch_done` in T+3.
  - The next accept is possible at T+4.
- The minimum batch is therefore 4 cycles from accept to the next `exec_ready`.
- A zero mask gives `batch_done` at T+1 and `perf_cycles`=0.
- `eu_done` arriving during LAUNCH is treated as stray. Units must not respond before the cycle after `eu_start`.
- Config writes take effect on `eu_cfg` the cycle after `cfg_valid`.
- A config write and a launch in the same cycle: the write is checked against the pre-launch `pending`, so the newly launched unit receives the new config.

## Test plan
- Single unit: cfg slot 2 = 0xA5A5_0001, launch mask 0x0004, done at WAIT+5 -> `eu_start`=0x0004 for one cycle, `eu_cfg` slot 2 = 0xA5A5_0001, one `batch_done` pulse, `perf_cycles`=7.
- Multi-unit: mask 0x1FFF, dones staggered with slots 0 and 12 in the same cycle -> `pending` decrements correctly, a single `batch_done` after the last done, `exec_ready` low throughout.
- Errors: done on slot 5 while idle -> `err`=3'b001; cfg write to a pending slot 3 -> `err[1]` set and `eu_cfg` slot 3 unchanged; `err_clr` -> `err`=0.
- Timeout with TIMEOUT_W=4: mask 0x0003, only slot 0 done -> after 15 WAIT cycles `eu_abort`=0x0002, `err[2]`=1, `batch_done` pulses.
- Back-to-back: `exec_valid` held with two masks -> second accepted exactly 4 cycles after the first for immediate dones; zero mask -> `batch_done` at T+1.
- Reset mid-WAIT with `pending`=0x0010 -> next cycle IDLE, all outputs and config registers 0, `exec_ready`=1.
